instr_fetch_unit: RTL and testbench

- Front end of the single-cycle MIPS datapath. Holds the PC and a word-addressed instruction memory, and presents the current instruction's opcode/func fields to the decode/control stage.
- Consumes decode's jump/branch/done outputs plus the ALU branch condition to select the next PC.
- A small run-control FSM handles idle/program-load, run and halt, including fault halts on bad fetch targets.

---
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Single-cycle MIPS fetch front end: PC, word-addressed instruction memory and run-control FSM.
// Optional retired-instruction counter enabled by defining PERF_COUNT_EN.
module instr_fetch_unit #(
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    input  logic               jump,
    input  logic               branch,
    input  logic               done,
    input  logic               branch_taken,
    input  logic [31:0]        jr_target,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [31:0]        instr,
    output logic [5:0]         opcode,
    output logic [5:0]         func,
    output logic               instr_valid,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        retired_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_r, state_nx_s;
    logic [31:0]         pc_r, pc_nx_s;
    logic                fault_r, fault_nx_s;
    logic [31:0]         instr_s, target_s, pc_plus4_s, br_off_s;
    logic [IMEM_AW-1:0]  ridx_s;
    logic [31:0]         mem_r [0:(1<<IMEM_AW)-1];

    // A fetch target must be word aligned and inside the memory.
    function automatic logic bad_target(input logic [31:0] t);
        bad_target = (t[1:0] != 2'b00) || ((t >> (IMEM_AW + 2)) != 32'd0);
    endfunction

    assign pc_plus4_s = pc_r + 32'd4;
    assign ridx_s     = pc_r[IMEM_AW+1:2];
    assign br_off_s   = {{14{instr_s[15]}}, instr_s[15:0], 2'b00};

    // Combinational instruction read; zero outside RUN.
    always_comb begin
        instr_s = 32'd0;
        if (state_r == ST_RUN) begin
            instr_s = mem_r[ridx_s];
        end else begin
            instr_s = 32'd0;
        end
    end

    // Next-PC candidate selection by control priority.
    always_comb begin
        target_s = pc_plus4_s;
        if (jump && (instr_s[31:26] == 6'd0)) begin
            target_s = jr_target;
        end else if (jump) begin
            target_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
        end else if (branch && branch_taken) begin
            target_s = pc_plus4_s + br_off_s;
        end else begin
            target_s = pc_plus4_s;
        end
    end

    // Run-control next state, PC update and fault capture.
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        fault_nx_s = fault_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                    pc_nx_s    = RESET_PC;
                    fault_nx_s = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RUN: begin
                if (done) begin
                    state_nx_s = ST_HALT;
                end else if (bad_target(target_s)) begin
                    state_nx_s = ST_HALT;
                    fault_nx_s = 1'b1;
                end else begin
                    pc_nx_s = target_s;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                pc_nx_s    = RESET_PC;
                fault_nx_s = 1'b0;
            end
        endcase
    end

    // State, PC and sticky fault registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= RESET_PC;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            fault_r <= fault_nx_s;
        end
    end

    // Program-load port; contents survive reset, writes are dropped while running.
    always_ff @(posedge clk) begin
        if (imem_we && (state_r != ST_RUN)) begin
            mem_r[imem_waddr] <= imem_wdata;
        end
    end

`ifdef PERF_COUNT_EN
    logic [31:0] retired_r;
    logic        retire_s, clr_s;

    assign retire_s = (state_r == ST_RUN) && !done;
    assign clr_s    = (start && (state_r != ST_RUN)) || (state_r == 2'd3);

    // Saturating count of retired (non-HALT) instructions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_r <= 32'd0;
        end else if (clr_s) begin
            retired_r <= 32'd0;
        end else if (retire_s && (retired_r != 32'hFFFF_FFFF)) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired_count = retired_r;
`else
    assign retired_count = 32'd0;
`endif

    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign instr       = instr_s;
    assign opcode      = instr_s[31:26];
    assign func        = instr_s[5:0];
    assign instr_valid = (state_r == ST_RUN);
    assign halted      = (state_r == ST_HALT);
    assign fault       = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed test-plan checks plus randomized run against a behavioural model.
module tb_instr_fetch_unit;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_we, jump, branch, done, branch_taken;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata, jr_target;
    logic [31:0] pc, pc_plus4, instr, retired_count;
    logic [5:0]  opcode, func;
    logic        instr_valid, halted, fault;

    instr_fetch_unit #(.IMEM_AW(8), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .jump(jump),
        .branch(branch), .done(done), .branch_taken(branch_taken),
        .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
        .opcode(opcode), .func(func), .instr_valid(instr_valid),
        .halted(halted), .fault(fault), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Model state: 0 idle, 1 run, 2 halt
    logic [31:0] m_mem [DEPTH];
    int          m_st;
    logic [31:0] m_pc, m_ret;
    logic        m_fault;
    bit          check_en = 1'b0;
    int          errs = 0;
    int          checks = 0;

    function automatic logic [31:0] m_instr();
        if (m_st == 1) return m_mem[(m_pc >> 2) % DEPTH];
        return 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ret();
`ifdef PERF_COUNT_EN
        return m_ret;
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk) begin : cmp
        logic [31:0] ei;
        if (check_en) begin
            ei = m_instr();
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("instr", instr, ei);
            chk("opcode", {26'd0, opcode}, {26'd0, ei[31:26]});
            chk("func", {26'd0, func}, {26'd0, ei[5:0]});
            chk("instr_valid", {31'd0, instr_valid}, (m_st == 1) ? 32'd1 : 32'd0);
            chk("halted", {31'd0, halted}, (m_st == 2) ? 32'd1 : 32'd0);
            chk("fault", {31'd0, fault}, {31'd0, m_fault});
            chk("retired_count", retired_count, exp_ret());
        end
    end

    task automatic model_step();
        logic [31:0] ins, tgt, p4;
        int off;
        if (!rst_n) begin
            m_st = 0; m_pc = 32'd0; m_fault = 1'b0; m_ret = 32'd0;
        end else begin
            ins = m_instr();
            p4  = m_pc + 32'd4;
            if (imem_we && m_st != 1) m_mem[imem_waddr] = imem_wdata;
            if (m_st != 1) begin
                if (start) begin
                    m_st = 1; m_pc = 32'd0; m_fault = 1'b0; m_ret = 32'd0;
                end
            end else if (done) begin
                m_st = 2;
            end else begin
                if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
                off = int'($signed(ins[15:0]));
                if (jump && ins[31:26] == 6'd0)      tgt = jr_target;
                else if (jump)                       tgt = (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
                else if (branch && branch_taken)     tgt = p4 + 32'(off * 4);
                else                                 tgt = p4;
                if ((tgt % 32'd4) != 32'd0 || tgt >= 32'(DEPTH * 4)) begin
                    m_fault = 1'b1; m_st = 2;
                end else begin
                    m_pc = tgt;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        start = 1'b0; imem_we = 1'b0; jump = 1'b0; branch = 1'b0;
        done = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        imem_we = 1'b1; imem_waddr = 8'(a); imem_wdata = d;
        cyc();
    endtask

    // Act as the decode stage for the current model instruction.
    task automatic decode();
        logic [31:0] ins;
        ins    = m_instr();
        done   = (m_st == 1) && (ins[31:26] == 6'd63);
        jump   = (ins[31:26] == 6'd2) || (ins[31:26] == 6'd0 && ins[5:0] == 6'd8);
        branch = (ins[31:26] == 6'd4);
    endtask

    function automatic logic [31:0] rword();
        logic [5:0]  opc;
        logic [15:0] imm;
        case ($urandom_range(0, 4))
            0: opc = 6'd0;
            1: opc = 6'd2;
            2: opc = 6'd4;
            3: opc = 6'd8;
            default: opc = 6'd63;
        endcase
        imm = 16'($urandom_range(0, 40) - 20);
        return {opc, 10'd0, imm};
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_we = 1'b0; imem_waddr = 8'd0; imem_wdata = 32'd0;
        jump = 1'b0; branch = 1'b0; done = 1'b0; branch_taken = 1'b0; jr_target = 32'd0;
        m_st = 0; m_pc = 32'd0; m_fault = 1'b0; m_ret = 32'd0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        cyc(); cyc();
        rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_instr", instr, 32'd0);

        // Straight-line code over the whole memory, falling off the end
        for (int i = 0; i < DEPTH; i++) load(i, 32'h2000_0000 | 32'(i));
        start = 1'b1; cyc();
        for (int i = 0; i < 255; i++) cyc();
        @(negedge clk);
        chk("falloff_last_pc", pc, 32'h0000_03FC);
        chk("falloff_last_instr", instr, 32'h2000_00FF);
        cyc();
        @(negedge clk);
        chk("falloff_fault", {31'd0, fault}, 32'd1);
        chk("falloff_halted", {31'd0, halted}, 32'd1);
        chk("falloff_pc", pc, 32'h0000_03FC);
`ifdef PERF_COUNT_EN
        chk("falloff_retired", retired_count, 32'd256);
`else
        chk("falloff_retired", retired_count, 32'd0);
`endif

        // ADDI, ADDI, ADD, HALT
        load(0, 32'h2001_0005); load(1, 32'h2002_0003); load(2, 32'h0022_1820); load(3, 32'hFC00_0000);
        start = 1'b1; cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_pc", pc, 32'(k * 4));
            decode();
            cyc();
        end
        @(negedge clk);
        chk("seq_halted", {31'd0, halted}, 32'd1);
        chk("seq_pc_end", pc, 32'd12);
        chk("seq_fault", {31'd0, fault}, 32'd0);
`ifdef PERF_COUNT_EN
        chk("seq_retired", retired_count, 32'd3);
`else
        chk("seq_retired", retired_count, 32'd0);
`endif

        // BEQ self-loop then fall-through
        load(1, 32'h1000_FFFF);
        start = 1'b1; cyc(); cyc();
        @(negedge clk); chk("beq_at", pc, 32'd4);
        branch = 1'b1; branch_taken = 1'b1; cyc();
        @(negedge clk); chk("beq_taken", pc, 32'd4);
        branch = 1'b1; branch_taken = 1'b0; cyc();
        @(negedge clk); chk("beq_not_taken", pc, 32'd8);
        done = 1'b1; cyc();

        // J, JR, misaligned JR
        load(0, 32'h0800_0010); load(16, 32'h0000_0008); load(8, 32'h0000_0008);
        start = 1'b1; cyc();
        jump = 1'b1; cyc();
        @(negedge clk); chk("j_pc", pc, 32'h40);
        jump = 1'b1; jr_target = 32'h20; cyc();
        @(negedge clk); chk("jr_pc", pc, 32'h20);
        jump = 1'b1; jr_target = 32'h22; cyc();
        @(negedge clk);
        chk("jr_bad_fault", {31'd0, fault}, 32'd1);
        chk("jr_bad_halted", {31'd0, halted}, 32'd1);
        chk("jr_bad_pc", pc, 32'h20);

        // Write in RUN dropped; write with start in HALT lands
        load(0, 32'h2000_0000); load(1, 32'h1000_FFFF);
        start = 1'b1; cyc(); cyc();
        branch = 1'b1; branch_taken = 1'b1; imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = 32'hDEAD_BEEF; cyc();
        @(negedge clk); chk("run_write_dropped", instr, 32'h1000_FFFF);
        done = 1'b1; cyc();
        imem_we = 1'b1; imem_waddr = 8'd0; imem_wdata = 32'h1234_5678; start = 1'b1; cyc();
        @(negedge clk);
        chk("halt_write_seen", instr, 32'h1234_5678);
        chk("halt_write_pc", pc, 32'd0);
        done = 1'b1; cyc();

        // Reset mid-run at pc 0x10, memory preserved
        start = 1'b1; cyc();
        for (int i = 0; i < 4; i++) cyc();
        @(negedge clk); chk("mid_pc", pc, 32'h10);
        rst_n = 1'b0; cyc();
        @(negedge clk);
        chk("mid_rst_pc", pc, 32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_retired", retired_count, 32'd0);
        rst_n = 1'b1; start = 1'b1; cyc();
        @(negedge clk); chk("mem_preserved", instr, 32'h1234_5678);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if (m_st != 1) begin
                start   = ($urandom_range(0, 7) == 0);
                imem_we = ($urandom_range(0, 2) == 0);
            end else begin
                start   = ($urandom_range(0, 19) == 0);
                imem_we = ($urandom_range(0, 19) == 0);
            end
            if (!rst_n) imem_we = 1'b0;
            imem_waddr   = 8'($urandom_range(0, 255));
            imem_wdata   = rword();
            done         = ($urandom_range(0, 39) == 0);
            jump         = ($urandom_range(0, 9) == 0);
            branch       = ($urandom_range(0, 3) == 0);
            branch_taken = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) jr_target = $urandom;
            else jr_target = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 7) == 0);
            cyc();
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
